// File: rtl/mac_acc_if.sv
// mac_acc_if: beat input bus and group result bus of the N-lane MAC accumulator.
// Latency: none, wires only.
// Backpressure: none; the producer may present a beat every cycle.
interface mac_acc_if #(
    parameter int WI = 8,
    parameter int N  = 16,
    parameter int WA = 32
);
    logic                 vld_i;
    logic                 first_i;
    logic                 last_i;
    logic [N*WI-1:0]      win;
    logic [N*WI-1:0]      din;
    logic signed [WA-1:0] acc_o;
    logic                 vld_o;
    logic                 sat_o;
    logic                 open_o;

    // Operand fetch side: drives beats, observes results.
    modport master (
        output vld_i, first_i, last_i, win, din,
        input  acc_o, vld_o, sat_o, open_o
    );

    // MAC side: consumes beats, produces group results.
    modport slave (
        input  vld_i, first_i, last_i, win, din,
        output acc_o, vld_o, sat_o, open_o
    );
endinterface

// File: rtl/mac_acc.sv
// mac_acc: N-lane signed MAC, pipelined adder tree, saturating multi-beat group accumulator.
// Latency: beat sampled at edge k with last -> vld_o high after edge k+$clog2(N)+2.
// Backpressure: none, one beat per cycle; optional ReLU on reported result via MAC_ACC_RELU_EN.
module mac_acc #(
    parameter int WI    = 8,
    parameter int N     = 16,
    parameter int WMODE = 0,
    parameter int WA    = 32
) (
    input logic     clk,
    input logic     rstn,
    mac_acc_if.slave bus
);
    localparam int WN  = $clog2(N);
    localparam int PW  = 2*WI + 2;    // per-lane product width
    localparam int SW  = PW + WN;     // tree sum width
    localparam int EXT = WA + 1 - SW; // sign bits added to reach the WA+1 adder

    if (WA < SW) begin : g_bad_wa
        $error("mac_acc: WA must be at least 2*WI+2+$clog2(N)");
    end
    if ((N < 2) || ((1 << WN) != N)) begin : g_bad_n
        $error("mac_acc: N must be a power of two and at least 2");
    end

    localparam logic signed [WA-1:0] ACC_MAX = {1'b0, {(WA-1){1'b1}}};
    localparam logic signed [WA-1:0] ACC_MIN = {1'b1, {(WA-1){1'b0}}};

    // Weight decode: odd-weight form stores w and means 2*w+1.
    function automatic logic signed [WI:0] enc_w(input logic [WI-1:0] w);
        if (WMODE == 0) return {w, 1'b1};
        else            return {w[WI-1], w};
    endfunction

    // ------------------------------------------------------------------
    // Stage 0: operand registers, loaded every cycle regardless of vld_i
    // ------------------------------------------------------------------
    logic signed [WI:0] w_r [N];
    logic signed [WI:0] a_r [N];

    // Capture decoded weights and zero-extended activations.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N; i++) begin
                w_r[i] <= '0;
                a_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                w_r[i] <= enc_w(bus.win[i*WI +: WI]);
                a_r[i] <= {1'b0, bus.din[i*WI +: WI]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Multiply and adder tree, laid out as a binary heap: node 0 is the
    // root, node i has children 2i+1 and 2i+2, leaves follow node N-2.
    // All nodes are carried at full tree width; the extra top bits of the
    // shallower levels are just sign copies.
    // ------------------------------------------------------------------
    logic signed [SW-1:0] leaf   [N];
    logic signed [SW-1:0] node_d [N-1];
    logic signed [SW-1:0] node_q [N-1];

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic signed [PW-1:0] prod;
        assign prod    = PW'(w_r[i]) * PW'(a_r[i]);
        assign leaf[i] = {{WN{prod[PW-1]}}, prod};
    end

    for (genvar i = 0; i < N-1; i++) begin : g_node
        if (2*i + 1 >= N - 1) begin : g_from_leaf
            assign node_d[i] = leaf[2*i+1-(N-1)] + leaf[2*i+2-(N-1)];
        end else begin : g_from_node
            assign node_d[i] = node_q[2*i+1] + node_q[2*i+2];
        end
    end

    // Register every tree level; one level of additions per cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N-1; i++) node_q[i] <= '0;
        end else begin
            node_q <= node_d;
        end
    end

    // ------------------------------------------------------------------
    // Sideband delay line: bit WN lines up with the tree root.
    // ------------------------------------------------------------------
    logic [WN:0] sb_vld, sb_first, sb_last;

    // Shift vld/first/last alongside the operands; framing is gated by vld_i.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sb_vld   <= '0;
            sb_first <= '0;
            sb_last  <= '0;
        end else begin
            sb_vld   <= {sb_vld[WN-1:0],   bus.vld_i};
            sb_first <= {sb_first[WN-1:0], bus.vld_i & bus.first_i};
            sb_last  <= {sb_last[WN-1:0],  bus.vld_i & bus.last_i};
        end
    end

    // ------------------------------------------------------------------
    // Accumulator stage
    // ------------------------------------------------------------------
    logic                 beat_vld, beat_first, beat_last;
    logic signed [WA-1:0] acc_q;
    logic                 sat_q;
    logic                 open_q;
    logic signed [WA:0]   acc_base, sum_x, acc_nxt;
    logic                 ovf;
    logic signed [WA-1:0] acc_clamp;
    logic                 sat_nxt;

    assign beat_vld   = sb_vld[WN];
    assign beat_first = sb_first[WN];
    assign beat_last  = sb_last[WN];

    // One extra bit of headroom: acc and sum both fit in WA bits, so the
    // WA+1-bit sum cannot wrap and the top two bits disagree only on overflow.
    assign acc_base  = beat_first ? '0 : {acc_q[WA-1], acc_q};
    assign sum_x     = {{EXT{node_q[0][SW-1]}}, node_q[0]};
    assign acc_nxt   = acc_base + sum_x;
    assign ovf       = acc_nxt[WA] ^ acc_nxt[WA-1];
    assign acc_clamp = ovf ? (acc_nxt[WA] ? ACC_MIN : ACC_MAX) : acc_nxt[WA-1:0];
    assign sat_nxt   = (beat_first ? 1'b0 : sat_q) | ovf;

    logic                 rpt_vld;
    logic signed [WA-1:0] rpt_acc;
    logic                 rpt_sat;

    // Accumulate valid beats; on last, hand the result to the output stage and clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q   <= '0;
            sat_q   <= 1'b0;
            open_q  <= 1'b0;
            rpt_vld <= 1'b0;
            rpt_acc <= '0;
            rpt_sat <= 1'b0;
        end else begin
            rpt_vld <= 1'b0;
            if (beat_vld) begin
                if (beat_last) begin
                    acc_q   <= '0;
                    sat_q   <= 1'b0;
                    open_q  <= 1'b0;
                    rpt_vld <= 1'b1;
                    rpt_acc <= acc_clamp;
                    rpt_sat <= sat_nxt;
                end else begin
                    acc_q   <= acc_clamp;
                    sat_q   <= sat_nxt;
                    open_q  <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    logic signed [WA-1:0] rpt_out;
`ifdef MAC_ACC_RELU_EN
    assign rpt_out = rpt_acc[WA-1] ? '0 : rpt_acc;
`else
    assign rpt_out = rpt_acc;
`endif

    logic signed [WA-1:0] acc_o_q;
    logic                 vld_o_q;
    logic                 sat_o_q;

    // Pulse vld_o for one cycle; acc_o/sat_o hold until the next report.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_o_q <= '0;
            vld_o_q <= 1'b0;
            sat_o_q <= 1'b0;
        end else begin
            vld_o_q <= rpt_vld;
            if (rpt_vld) begin
                acc_o_q <= rpt_out;
                sat_o_q <= rpt_sat;
            end
        end
    end

    assign bus.acc_o  = acc_o_q;
    assign bus.vld_o  = vld_o_q;
    assign bus.sat_o  = sat_o_q;
    assign bus.open_o = open_q;

endmodule

// File: tb/tb_mac_acc.sv
// tb_mac_acc: directed stimulus on three mac_acc builds (default, WA=22, WMODE=1).
// Expected results are queued with the cycle they are due; monitors compare on output.
// Honours MAC_ACC_RELU_EN for the expected value of negative results.
module tb_mac_acc;
    localparam int LAT = 6; // edges from sampling the last beat to vld_o, N=16

`ifdef MAC_ACC_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    localparam int SA = 0; // default build
    localparam int SS = 1; // WA=22 build
    localparam int SM = 2; // WMODE=1 build

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    mac_acc_if #(.WI(8), .N(16), .WA(32)) ifa ();
    mac_acc_if #(.WI(8), .N(16), .WA(22)) ifs ();
    mac_acc_if #(.WI(8), .N(16), .WA(32)) ifm ();

    mac_acc #(.WI(8), .N(16), .WMODE(0), .WA(32)) dut_a (.clk(clk), .rstn(rstn), .bus(ifa.slave));
    mac_acc #(.WI(8), .N(16), .WMODE(0), .WA(22)) dut_s (.clk(clk), .rstn(rstn), .bus(ifs.slave));
    mac_acc #(.WI(8), .N(16), .WMODE(1), .WA(32)) dut_m (.clk(clk), .rstn(rstn), .bus(ifm.slave));

    typedef struct {
        longint acc;
        logic   sat;
        int     cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_s[$];
    exp_t q_m[$];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int drv_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function void chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic longint relu(input longint v);
        return (RELU && v < 0) ? 64'sd0 : v;
    endfunction

    function automatic logic [127:0] rep(input logic [7:0] b);
        return {16{b}};
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        exp_t e;
        logic due;
        due = (q_a.size() > 0) && (q_a[0].cyc == cyc);
        if (ifa.vld_o || due) begin
            chk("a_vld", ifa.vld_o, due);
            if (due) begin
                e = q_a.pop_front();
                chk("a_acc", ifa.acc_o, e.acc);
                chk("a_sat", ifa.sat_o, e.sat);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        logic due;
        due = (q_s.size() > 0) && (q_s[0].cyc == cyc);
        if (ifs.vld_o || due) begin
            chk("s_vld", ifs.vld_o, due);
            if (due) begin
                e = q_s.pop_front();
                chk("s_acc", ifs.acc_o, e.acc);
                chk("s_sat", ifs.sat_o, e.sat);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        logic due;
        due = (q_m.size() > 0) && (q_m[0].cyc == cyc);
        if (ifm.vld_o || due) begin
            chk("m_vld", ifm.vld_o, due);
            if (due) begin
                e = q_m.pop_front();
                chk("m_acc", ifm.acc_o, e.acc);
                chk("m_sat", ifm.sat_o, e.sat);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic clear_inputs();
        ifa.vld_i = 1'b0; ifa.first_i = 1'b0; ifa.last_i = 1'b0;
        ifs.vld_i = 1'b0; ifs.first_i = 1'b0; ifs.last_i = 1'b0;
        ifm.vld_i = 1'b0; ifm.first_i = 1'b0; ifm.last_i = 1'b0;
    endtask

    task automatic drive(input int sel, input logic f, input logic l,
                         input logic [127:0] wv, input logic [127:0] dv);
        @(negedge clk);
        drv_cyc = cyc;
        clear_inputs();
        case (sel)
            SA: begin ifa.vld_i = 1'b1; ifa.first_i = f; ifa.last_i = l; ifa.win = wv; ifa.din = dv; end
            SS: begin ifs.vld_i = 1'b1; ifs.first_i = f; ifs.last_i = l; ifs.win = wv; ifs.din = dv; end
            default: begin ifm.vld_i = 1'b1; ifm.first_i = f; ifm.last_i = l; ifm.win = wv; ifm.din = dv; end
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            clear_inputs();
        end
    endtask

    // Expected result for the beat just driven; due LAT edges after it is sampled.
    task automatic push(input int sel, input longint acc, input logic sat);
        exp_t e;
        e.acc = acc;
        e.sat = sat;
        e.cyc = drv_cyc + 1 + LAT;
        case (sel)
            SA: q_a.push_back(e);
            SS: q_s.push_back(e);
            default: q_m.push_back(e);
        endcase
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] v;
        rstn = 1'b0;
        clear_inputs();
        ifa.win = '0; ifa.din = '0;
        ifs.win = '0; ifs.din = '0;
        ifm.win = '0; ifm.din = '0;
        repeat (2) @(negedge clk);
        chk("rst_acc_o",  ifa.acc_o,  0);
        chk("rst_vld_o",  ifa.vld_o,  0);
        chk("rst_sat_o",  ifa.sat_o,  0);
        chk("rst_open_o", ifa.open_o, 0);
        rstn = 1'b1;
        idle(2);

        // Single beat, weight 1, din 1 -> 16
        drive(SA, 1, 1, rep(8'h00), rep(8'h01)); push(SA, 16, 0);
        // Per-lane weights 2i+1, din 1 -> 256
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = 8'(i);
        drive(SA, 1, 1, v, rep(8'h01)); push(SA, 256, 0);
        // Weight 1, per-lane din i -> 120
        drive(SA, 1, 1, rep(8'h00), v); push(SA, 120, 0);
        // Weight -1, din 255 -> -4080
        drive(SA, 1, 1, rep(8'hFF), rep(8'hFF)); push(SA, relu(-4080), 0);
        idle(8);

        // Three-beat group with bubbles -> 48, open_o high meanwhile
        drive(SA, 1, 0, rep(8'h00), rep(8'h01));
        idle(2);
        drive(SA, 0, 0, rep(8'h00), rep(8'h01));
        idle(1);
        drive(SA, 0, 1, rep(8'h00), rep(8'h01)); push(SA, 48, 0);
        idle(2);
        chk("open_mid_group", ifa.open_o, 1);
        idle(6);
        chk("open_after_rpt", ifa.open_o, 0);

        // Non-first beat with no open group -> 16
        drive(SA, 0, 1, rep(8'h00), rep(8'h01)); push(SA, 16, 0);
        // first while open: partial 32 discarded, new group 32+16 -> 48
        drive(SA, 1, 0, rep(8'h00), rep(8'h01));
        drive(SA, 0, 0, rep(8'h00), rep(8'h01));
        drive(SA, 1, 0, rep(8'h00), rep(8'h02));
        drive(SA, 0, 1, rep(8'h00), rep(8'h01)); push(SA, 48, 0);
        idle(8);

        // Saturation, WA=22: 3 x 1040400 clamps to 2097151
        drive(SS, 1, 0, rep(8'h7F), rep(8'hFF));
        drive(SS, 0, 0, rep(8'h7F), rep(8'hFF));
        drive(SS, 0, 1, rep(8'h7F), rep(8'hFF)); push(SS, 2097151, 1);
        // Next group starts clean: 2 x 1040400
        drive(SS, 1, 0, rep(8'h7F), rep(8'hFF));
        drive(SS, 0, 1, rep(8'h7F), rep(8'hFF)); push(SS, 2080800, 0);

        // WMODE=1, back-to-back single-beat groups
        drive(SM, 1, 1, rep(8'hFE), rep(8'h03)); push(SM, relu(-96), 0);
        drive(SM, 1, 1, rep(8'h03), rep(8'h01)); push(SM, 48, 0);
        drive(SM, 1, 1, rep(8'hFE), rep(8'h02)); push(SM, relu(-64), 0);
        drive(SM, 1, 1, rep(8'h03), rep(8'h05)); push(SM, 240, 0);
        drive(SM, 1, 1, rep(8'h7F), rep(8'hFF)); push(SM, 518160, 0);
        drive(SM, 1, 1, rep(8'h80), rep(8'hFF)); push(SM, relu(-522240), 0);
        idle(10);

        // Reset in the middle of a 4-beat group
        drive(SA, 1, 0, rep(8'h00), rep(8'h01));
        drive(SA, 0, 0, rep(8'h00), rep(8'h01));
        @(negedge clk);
        clear_inputs();
        rstn = 1'b0;
        #1;
        chk("mid_rst_acc_o",  ifa.acc_o,  0);
        chk("mid_rst_vld_o",  ifa.vld_o,  0);
        chk("mid_rst_sat_o",  ifa.sat_o,  0);
        chk("mid_rst_open_o", ifa.open_o, 0);
        chk("mid_rst_s_acc",  ifs.acc_o,  0);
        chk("mid_rst_m_acc",  ifm.acc_o,  0);
        idle(3);
        rstn = 1'b1;
        idle(10);
        drive(SA, 1, 1, rep(8'h00), rep(8'h02)); push(SA, 32, 0);
        idle(2);

        // Drain, bounded
        for (int i = 0; i < 50; i++) begin
            if (q_a.size() == 0 && q_s.size() == 0 && q_m.size() == 0) break;
            @(negedge clk);
        end
        idle(4);
        chk("drain_a", q_a.size(), 0);
        chk("drain_s", q_s.size(), 0);
        chk("drain_m", q_m.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
